// File: rtl/ddc_buf_reader.sv
`default_nettype none
// ============================================================================
// Module   : ddc_buf_reader
// Desc     : Drains the DDC ring buffer in BLK_LEN-word blocks onto a stream.
//            Optional macro DDC_RD_OVF_DET_EN enables lagging-reader detection.
// Revision : 1.0
// ============================================================================
module ddc_buf_reader #(
    parameter int unsigned U_DLY     = 1,
    parameter int unsigned BUF_DEPTH = 11520,
    parameter int unsigned WPTR_ADDR = 11521,
    parameter int unsigned BLK_LEN   = 256,
    parameter int unsigned POLL_GAP  = 64
) (
    input  logic        rst_n,
    input  logic        lbs_clk,
    input  logic        enable,
    output logic [15:0] lbs_addr,
    output logic        lbs_re,
    input  logic [31:0] lbs_rdata,
    output logic        m_tvalid,
    output logic [31:0] m_tdata,
    output logic        m_tlast,
    input  logic        m_tready,
    output logic [13:0] rptr,
    output logic        ovf
);

    localparam int unsigned C_FIFO_DEPTH = 8;
    localparam int unsigned C_ISS_W      = $clog2(BLK_LEN + 1);
    localparam int unsigned C_OUT_W      = $clog2(BLK_LEN);
    localparam int unsigned C_GAP_W      = $clog2(POLL_GAP + 1);
    localparam logic [13:0] C_DEPTH14    = 14'(BUF_DEPTH);
    localparam logic [14:0] C_DEPTH15    = 15'(BUF_DEPTH);
    localparam logic [14:0] C_BLK15      = 15'(BLK_LEN);
`ifdef DDC_RD_OVF_DET_EN
    localparam logic [14:0] C_OVF_LIM    = 15'(BUF_DEPTH - BLK_LEN);
`endif

    // The delay parameter is kept for drop-in compatibility; this RTL is zero-delay.
    if (U_DLY != 0) begin : g_sim_dly
    end

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_POLL  = 3'd1,
        S_WAITW = 3'd2,
        S_CALC  = 3'd3,
        S_GAP   = 3'd4,
        S_READ  = 3'd5,
        S_DRAIN = 3'd6
    } state_t;

    state_t               state_q,    state_d;
    logic [15:0]          lbs_addr_q, lbs_addr_d;
    logic                 lbs_re_q,   lbs_re_d;
    logic [13:0]          rptr_q,     rptr_d;
    logic [13:0]          wptr_q,     wptr_d;
    logic                 wait_q,     wait_d;
    logic [C_GAP_W-1:0]   gap_cnt_q,  gap_cnt_d;
    logic [C_ISS_W-1:0]   iss_cnt_q,  iss_cnt_d;
    logic [1:0]           pipe_q,     pipe_d;
    logic [1:0]           infl_q,     infl_d;
    logic [31:0]          fifo_mem_q [C_FIFO_DEPTH];
    logic [31:0]          fifo_mem_d [C_FIFO_DEPTH];
    logic [2:0]           wr_ptr_q,   wr_ptr_d;
    logic [2:0]           rd_ptr_q,   rd_ptr_d;
    logic [3:0]           fifo_cnt_q, fifo_cnt_d;
    logic [C_OUT_W-1:0]   out_cnt_q,  out_cnt_d;
`ifdef DDC_RD_OVF_DET_EN
    logic                 ovf_q,      ovf_d;
`endif

    logic [14:0] avail;
    logic        issue_ok;
    logic        data_iss;
    logic        push;
    logic        pop;

    // Samples between our read pointer and the writer, modulo the ring size.
    always_comb begin
        avail = '0;
        if (wptr_q >= C_DEPTH14) begin
            avail = '0;
        end else if (wptr_q >= rptr_q) begin
            avail = {1'b0, wptr_q} - {1'b0, rptr_q};
        end else begin
            avail = {1'b0, wptr_q} + C_DEPTH15 - {1'b0, rptr_q};
        end
    end

    // Reserve a FIFO slot for every read still in the return pipe.
    assign issue_ok = (fifo_cnt_q + {2'b00, infl_q}) < 4'd8;

    always_comb begin
        state_d    = state_q;
        lbs_addr_d = lbs_addr_q;
        lbs_re_d   = 1'b0;
        rptr_d     = rptr_q;
        wptr_d     = wptr_q;
        wait_d     = wait_q;
        gap_cnt_d  = gap_cnt_q;
        iss_cnt_d  = iss_cnt_q;
        data_iss   = 1'b0;
`ifdef DDC_RD_OVF_DET_EN
        ovf_d      = ovf_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d = S_POLL;
                end
            end
            S_POLL: begin
                lbs_addr_d = 16'(WPTR_ADDR);
                lbs_re_d   = 1'b1;
                wait_d     = 1'b0;
                state_d    = S_WAITW;
            end
            S_WAITW: begin
                if (wait_q) begin
                    wptr_d  = lbs_rdata[13:0];
                    state_d = S_CALC;
                end else begin
                    wait_d = 1'b1;
                end
            end
            S_CALC: begin
                gap_cnt_d = '0;
                iss_cnt_d = '0;
                state_d   = (avail >= C_BLK15) ? S_READ : S_GAP;
`ifdef DDC_RD_OVF_DET_EN
                if (avail > C_OVF_LIM) begin
                    ovf_d   = 1'b1;
                    rptr_d  = wptr_q;
                    state_d = S_GAP;
                end
`endif
            end
            S_GAP: begin
                if (gap_cnt_q == C_GAP_W'(POLL_GAP - 1)) begin
                    state_d = enable ? S_POLL : S_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + C_GAP_W'(1);
                end
            end
            S_READ: begin
                if (issue_ok) begin
                    lbs_addr_d = {2'b00, rptr_q};
                    lbs_re_d   = 1'b1;
                    data_iss   = 1'b1;
                    rptr_d     = (rptr_q == C_DEPTH14 - 14'd1) ? 14'd0 : rptr_q + 14'd1;
                    iss_cnt_d  = iss_cnt_q + C_ISS_W'(1);
                    if (iss_cnt_q == C_ISS_W'(BLK_LEN - 1)) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (infl_q == 2'd0) begin
                    state_d = enable ? S_POLL : S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Return path: data lands two edges after its strobe, then enters the FIFO.
    assign push = pipe_q[1];
    assign pop  = m_tvalid && m_tready;

    always_comb begin
        pipe_d     = {pipe_q[0], data_iss};
        infl_d     = infl_q;
        fifo_mem_d = fifo_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q;
        out_cnt_d  = out_cnt_q;

        case ({data_iss, push})
            2'b10:   infl_d = infl_q + 2'd1;
            2'b01:   infl_d = infl_q - 2'd1;
            default: infl_d = infl_q;
        endcase

        if (push) begin
            fifo_mem_d[wr_ptr_q] = lbs_rdata;
            wr_ptr_d             = wr_ptr_q + 3'd1;
        end
        if (pop) begin
            rd_ptr_d  = rd_ptr_q + 3'd1;
            out_cnt_d = (out_cnt_q == C_OUT_W'(BLK_LEN - 1)) ? '0 : out_cnt_q + C_OUT_W'(1);
        end

        case ({push, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + 4'd1;
            2'b01:   fifo_cnt_d = fifo_cnt_q - 4'd1;
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
    end

    always_ff @(posedge lbs_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            lbs_addr_q <= '0;
            lbs_re_q   <= 1'b0;
            rptr_q     <= '0;
            wptr_q     <= '0;
            wait_q     <= 1'b0;
            gap_cnt_q  <= '0;
            iss_cnt_q  <= '0;
            pipe_q     <= '0;
            infl_q     <= '0;
            fifo_mem_q <= '{default: '0};
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
            out_cnt_q  <= '0;
`ifdef DDC_RD_OVF_DET_EN
            ovf_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            lbs_addr_q <= lbs_addr_d;
            lbs_re_q   <= lbs_re_d;
            rptr_q     <= rptr_d;
            wptr_q     <= wptr_d;
            wait_q     <= wait_d;
            gap_cnt_q  <= gap_cnt_d;
            iss_cnt_q  <= iss_cnt_d;
            pipe_q     <= pipe_d;
            infl_q     <= infl_d;
            fifo_mem_q <= fifo_mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
            out_cnt_q  <= out_cnt_d;
`ifdef DDC_RD_OVF_DET_EN
            ovf_q      <= ovf_d;
`endif
        end
    end

    assign lbs_addr = lbs_addr_q;
    assign lbs_re   = lbs_re_q;
    assign rptr     = rptr_q;
    assign m_tvalid = (fifo_cnt_q != 4'd0);
    assign m_tdata  = m_tvalid ? fifo_mem_q[rd_ptr_q] : 32'd0;
    assign m_tlast  = m_tvalid && (out_cnt_q == C_OUT_W'(BLK_LEN - 1));

`ifdef DDC_RD_OVF_DET_EN
    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ddc_buf_reader.sv
`default_nettype none
// Bench for ddc_buf_reader: registered ring-buffer port model, stream monitor
// and per-scenario tasks checked against a sequential-address reference model.
module tb_ddc_buf_reader;

    localparam int BUF_DEPTH = 11520;
    localparam int WPTR_ADDR = 11521;
    localparam int BLK_LEN   = 256;
    localparam int POLL_GAP  = 64;

    logic        rst_n    = 1'b1;
    logic        lbs_clk  = 1'b0;
    logic        enable   = 1'b0;
    logic        m_tready = 1'b0;
    logic [31:0] lbs_rdata = 32'd0;
    logic [15:0] lbs_addr;
    logic        lbs_re;
    logic        m_tvalid;
    logic [31:0] m_tdata;
    logic        m_tlast;
    logic [13:0] rptr;
    logic        ovf;

    logic [31:0] mem [0:BUF_DEPTH-1];
    logic [13:0] wptr = 14'd0;

    int n_checks  = 0;
    int n_fail    = 0;
    int cyc       = 0;
    int hold_viol = 0;
    int addr_q[$];
    int poll_q[$];
    logic [32:0] out_q[$];
    logic        prev_stall = 1'b0;
    logic [32:0] prev_word  = 33'd0;

    ddc_buf_reader #(
        .U_DLY     (1),
        .BUF_DEPTH (BUF_DEPTH),
        .WPTR_ADDR (WPTR_ADDR),
        .BLK_LEN   (BLK_LEN),
        .POLL_GAP  (POLL_GAP)
    ) dut (
        .rst_n     (rst_n),
        .lbs_clk   (lbs_clk),
        .enable    (enable),
        .lbs_addr  (lbs_addr),
        .lbs_re    (lbs_re),
        .lbs_rdata (lbs_rdata),
        .m_tvalid  (m_tvalid),
        .m_tdata   (m_tdata),
        .m_tlast   (m_tlast),
        .m_tready  (m_tready),
        .rptr      (rptr),
        .ovf       (ovf)
    );

    always #5 lbs_clk = ~lbs_clk;

    // Buffer port: one registered stage between strobe and data.
    always @(posedge lbs_clk) begin
        if (lbs_re) begin
            if (lbs_addr == 16'(WPTR_ADDR))
                lbs_rdata <= {18'd0, wptr};
            else if (int'(lbs_addr) < BUF_DEPTH)
                lbs_rdata <= mem[lbs_addr];
            else
                lbs_rdata <= 32'hDEAD_BEEF;
        end
    end

    // Observation only: records strobes, accepted words and valid-hold breaks.
    always @(negedge lbs_clk) begin
        cyc++;
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (lbs_re && lbs_addr == 16'(WPTR_ADDR)) poll_q.push_back(cyc);
            else if (lbs_re) addr_q.push_back(int'(lbs_addr));
            if (prev_stall && (!m_tvalid || {m_tlast, m_tdata} !== prev_word)) hold_viol++;
            if (m_tvalid && m_tready) out_q.push_back({m_tlast, m_tdata});
            prev_stall = m_tvalid && !m_tready;
            prev_word  = {m_tlast, m_tdata};
        end
    end

    task automatic do_reset();
        rst_n    = 1'b0;
        enable   = 1'b0;
        m_tready = 1'b0;
        repeat (3) @(posedge lbs_clk);
        #1;
        addr_q.delete();
        poll_q.delete();
        out_q.delete();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #3 rst_n = 1'b0;
        #1;
        n_checks++; if (lbs_addr !== 16'd0) begin n_fail++; $display("FAIL rst_lbs_addr: got %0h expected 0", lbs_addr); end
        n_checks++; if (lbs_re !== 1'b0)    begin n_fail++; $display("FAIL rst_lbs_re: got %0b expected 0", lbs_re); end
        n_checks++; if (m_tvalid !== 1'b0)  begin n_fail++; $display("FAIL rst_m_tvalid: got %0b expected 0", m_tvalid); end
        n_checks++; if (m_tdata !== 32'd0)  begin n_fail++; $display("FAIL rst_m_tdata: got %0h expected 0", m_tdata); end
        n_checks++; if (m_tlast !== 1'b0)   begin n_fail++; $display("FAIL rst_m_tlast: got %0b expected 0", m_tlast); end
        n_checks++; if (rptr !== 14'd0)     begin n_fail++; $display("FAIL rst_rptr: got %0d expected 0", rptr); end
        n_checks++; if (ovf !== 1'b0)       begin n_fail++; $display("FAIL rst_ovf: got %0b expected 0", ovf); end
        do_reset();
    endtask

    task automatic test_idle_poll();
        do_reset();
        wptr = 14'd0; m_tready = 1'b1; enable = 1'b1;
        repeat (300) @(posedge lbs_clk);
        #1;
        n_checks++; if (poll_q.size() < 4) begin n_fail++; $display("FAIL poll_count: got %0d expected >=4", poll_q.size()); end
        for (int i = 1; i < poll_q.size(); i++) begin
            n_checks++;
            if (poll_q[i] - poll_q[i-1] !== POLL_GAP + 4) begin
                n_fail++; $display("FAIL poll_interval[%0d]: got %0d expected %0d", i, poll_q[i] - poll_q[i-1], POLL_GAP + 4);
            end
        end
        n_checks++; if (addr_q.size() !== 0) begin n_fail++; $display("FAIL idle_addr_count: got %0d expected 0", addr_q.size()); end
        n_checks++; if (out_q.size() !== 0)  begin n_fail++; $display("FAIL idle_out_count: got %0d expected 0", out_q.size()); end
        enable = 1'b0;
        repeat (100) @(posedge lbs_clk);
        #1 poll_q.delete();
        repeat (200) @(posedge lbs_clk);
        #1;
        n_checks++; if (poll_q.size() !== 0) begin n_fail++; $display("FAIL disabled_polls: got %0d expected 0", poll_q.size()); end
    endtask

    task automatic test_single_block();
        int n;
        do_reset();
        wptr = 14'd256; m_tready = 1'b1; enable = 1'b1;
        for (int c = 0; c < 2000 && out_q.size() < 256; c++) @(posedge lbs_clk);
        repeat (150) @(posedge lbs_clk);
        #1;
        n_checks++; if (addr_q.size() !== 256) begin n_fail++; $display("FAIL single_addr_count: got %0d expected 256", addr_q.size()); end
        n_checks++; if (out_q.size() !== 256)  begin n_fail++; $display("FAIL single_out_count: got %0d expected 256", out_q.size()); end
        n = (out_q.size() < 256) ? out_q.size() : 256;
        if (addr_q.size() < n) n = addr_q.size();
        for (int i = 0; i < n; i++) begin
            logic [32:0] exp_w;
            exp_w = {((i % BLK_LEN) == BLK_LEN - 1), mem[i]};
            n_checks++; if (addr_q[i] !== i)     begin n_fail++; $display("FAIL single_addr[%0d]: got %0d expected %0d", i, addr_q[i], i); end
            n_checks++; if (out_q[i] !== exp_w)  begin n_fail++; $display("FAIL single_word[%0d]: got %0h expected %0h", i, out_q[i], exp_w); end
        end
        n_checks++; if (rptr !== 14'd256) begin n_fail++; $display("FAIL single_rptr: got %0d expected 256", rptr); end
    endtask

    task automatic test_backpressure();
        int n;
        int hv0;
        do_reset();
        hv0 = hold_viol;
        wptr = 14'd512; enable = 1'b1;
        for (int c = 0; c < 6000 && out_q.size() < 512; c++) begin
            m_tready = ((c / 3) % 2) == 0;
            @(posedge lbs_clk);
            #1;
        end
        m_tready = 1'b1;
        repeat (150) @(posedge lbs_clk);
        #1;
        n_checks++; if (out_q.size() !== 512)  begin n_fail++; $display("FAIL bp_out_count: got %0d expected 512", out_q.size()); end
        n_checks++; if (addr_q.size() !== 512) begin n_fail++; $display("FAIL bp_addr_count: got %0d expected 512", addr_q.size()); end
        n = (out_q.size() < 512) ? out_q.size() : 512;
        for (int i = 0; i < n; i++) begin
            logic [32:0] exp_w;
            exp_w = {((i % BLK_LEN) == BLK_LEN - 1), mem[i]};
            n_checks++; if (out_q[i] !== exp_w) begin n_fail++; $display("FAIL bp_word[%0d]: got %0h expected %0h", i, out_q[i], exp_w); end
        end
        n_checks++; if (hold_viol !== hv0) begin n_fail++; $display("FAIL bp_valid_hold: got %0d breaks expected 0", hold_viol - hv0); end
        n_checks++; if (rptr !== 14'd512)  begin n_fail++; $display("FAIL bp_rptr: got %0d expected 512", rptr); end
    endtask

    task automatic test_wrap();
        int n;
        int hv0;
        localparam int TOTAL = BUF_DEPTH;
        do_reset();
        hv0 = hold_viol;
        wptr = 14'd11264; enable = 1'b1;
        for (int c = 0; c < 40000 && out_q.size() < TOTAL; c++) begin
            m_tready = ($urandom_range(0, 3) != 0);
            if (addr_q.size() >= BUF_DEPTH - BLK_LEN) wptr = 14'd0;
            @(posedge lbs_clk);
            #1;
        end
        m_tready = 1'b1;
        repeat (150) @(posedge lbs_clk);
        #1;
        n_checks++; if (out_q.size() !== TOTAL)  begin n_fail++; $display("FAIL wrap_out_count: got %0d expected %0d", out_q.size(), TOTAL); end
        n_checks++; if (addr_q.size() !== TOTAL) begin n_fail++; $display("FAIL wrap_addr_count: got %0d expected %0d", addr_q.size(), TOTAL); end
        n = (out_q.size() < TOTAL) ? out_q.size() : TOTAL;
        if (addr_q.size() < n) n = addr_q.size();
        for (int i = 0; i < n; i++) begin
            logic [32:0] exp_w;
            exp_w = {((i % BLK_LEN) == BLK_LEN - 1), mem[i % BUF_DEPTH]};
            n_checks++; if (addr_q[i] !== i % BUF_DEPTH) begin n_fail++; $display("FAIL wrap_addr[%0d]: got %0d expected %0d", i, addr_q[i], i % BUF_DEPTH); end
            n_checks++; if (out_q[i] !== exp_w)         begin n_fail++; $display("FAIL wrap_word[%0d]: got %0h expected %0h", i, out_q[i], exp_w); end
        end
        n_checks++; if (hold_viol !== hv0) begin n_fail++; $display("FAIL wrap_valid_hold: got %0d breaks expected 0", hold_viol - hv0); end
        n_checks++; if (rptr !== 14'd0)    begin n_fail++; $display("FAIL wrap_rptr: got %0d expected 0", rptr); end
    endtask

    task automatic test_reset_mid_block();
        int n;
        do_reset();
        wptr = 14'd256; m_tready = 1'b1; enable = 1'b1;
        for (int c = 0; c < 1000 && out_q.size() < 100; c++) @(posedge lbs_clk);
        #1 rst_n = 1'b0;
        #1;
        n_checks++; if (lbs_addr !== 16'd0) begin n_fail++; $display("FAIL mid_rst_lbs_addr: got %0h expected 0", lbs_addr); end
        n_checks++; if (lbs_re !== 1'b0)    begin n_fail++; $display("FAIL mid_rst_lbs_re: got %0b expected 0", lbs_re); end
        n_checks++; if (m_tvalid !== 1'b0)  begin n_fail++; $display("FAIL mid_rst_m_tvalid: got %0b expected 0", m_tvalid); end
        n_checks++; if (m_tdata !== 32'd0)  begin n_fail++; $display("FAIL mid_rst_m_tdata: got %0h expected 0", m_tdata); end
        n_checks++; if (m_tlast !== 1'b0)   begin n_fail++; $display("FAIL mid_rst_m_tlast: got %0b expected 0", m_tlast); end
        n_checks++; if (rptr !== 14'd0)     begin n_fail++; $display("FAIL mid_rst_rptr: got %0d expected 0", rptr); end
        repeat (2) @(posedge lbs_clk);
        #1;
        addr_q.delete(); out_q.delete(); poll_q.delete();
        rst_n = 1'b1;
        for (int c = 0; c < 2000 && out_q.size() < 256; c++) @(posedge lbs_clk);
        repeat (150) @(posedge lbs_clk);
        #1;
        n_checks++; if (out_q.size() !== 256) begin n_fail++; $display("FAIL restart_out_count: got %0d expected 256", out_q.size()); end
        n = (out_q.size() < 256) ? out_q.size() : 256;
        if (addr_q.size() < n) n = addr_q.size();
        for (int i = 0; i < n; i++) begin
            logic [32:0] exp_w;
            exp_w = {((i % BLK_LEN) == BLK_LEN - 1), mem[i]};
            n_checks++; if (addr_q[i] !== i)    begin n_fail++; $display("FAIL restart_addr[%0d]: got %0d expected %0d", i, addr_q[i], i); end
            n_checks++; if (out_q[i] !== exp_w) begin n_fail++; $display("FAIL restart_word[%0d]: got %0h expected %0h", i, out_q[i], exp_w); end
        end
        n_checks++; if (rptr !== 14'd256) begin n_fail++; $display("FAIL restart_rptr: got %0d expected 256", rptr); end
    endtask

    task automatic test_ovf();
        int n;
        int start;
        do_reset();
        wptr = 14'd11400; m_tready = 1'b1; enable = 1'b1;
`ifdef DDC_RD_OVF_DET_EN
        for (int c = 0; c < 300 && ovf !== 1'b1; c++) @(posedge lbs_clk);
        #1;
        n_checks++; if (ovf !== 1'b1)        begin n_fail++; $display("FAIL ovf_flag: got %0b expected 1", ovf); end
        n_checks++; if (rptr !== 14'd11400)  begin n_fail++; $display("FAIL ovf_resync_rptr: got %0d expected 11400", rptr); end
        n_checks++; if (out_q.size() !== 0)  begin n_fail++; $display("FAIL ovf_out_count: got %0d expected 0", out_q.size()); end
        n_checks++; if (addr_q.size() !== 0) begin n_fail++; $display("FAIL ovf_addr_count: got %0d expected 0", addr_q.size()); end
        // A block straddling the end of the ring after the resync.
        wptr  = 14'd136;
        start = 11400;
        for (int c = 0; c < 2000 && out_q.size() < 256; c++) @(posedge lbs_clk);
        repeat (150) @(posedge lbs_clk);
        #1;
        n_checks++; if (rptr !== 14'd136) begin n_fail++; $display("FAIL ovf_wrap_rptr: got %0d expected 136", rptr); end
        n_checks++; if (ovf !== 1'b1)     begin n_fail++; $display("FAIL ovf_sticky: got %0b expected 1", ovf); end
`else
        start = 0;
        for (int c = 0; c < 300 && addr_q.size() < 1; c++) @(posedge lbs_clk);
        #1 enable = 1'b0;
        repeat (600) @(posedge lbs_clk);
        #1;
        n_checks++; if (ovf !== 1'b0)       begin n_fail++; $display("FAIL noovf_flag: got %0b expected 0", ovf); end
        n_checks++; if (rptr !== 14'd256)   begin n_fail++; $display("FAIL noovf_rptr: got %0d expected 256", rptr); end
`endif
        n_checks++; if (out_q.size() !== 256)  begin n_fail++; $display("FAIL large_avail_out_count: got %0d expected 256", out_q.size()); end
        n_checks++; if (addr_q.size() !== 256) begin n_fail++; $display("FAIL large_avail_addr_count: got %0d expected 256", addr_q.size()); end
        n = (out_q.size() < 256) ? out_q.size() : 256;
        if (addr_q.size() < n) n = addr_q.size();
        for (int i = 0; i < n; i++) begin
            logic [32:0] exp_w;
            int a;
            a     = (start + i) % BUF_DEPTH;
            exp_w = {((i % BLK_LEN) == BLK_LEN - 1), mem[a]};
            n_checks++; if (addr_q[i] !== a)    begin n_fail++; $display("FAIL large_avail_addr[%0d]: got %0d expected %0d", i, addr_q[i], a); end
            n_checks++; if (out_q[i] !== exp_w) begin n_fail++; $display("FAIL large_avail_word[%0d]: got %0h expected %0h", i, out_q[i], exp_w); end
        end
    endtask

    initial begin
        #2_000_000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached, %0d failures so far", n_fail);
        $fatal(1, "time limit");
    end

    initial begin
        for (int i = 0; i < BUF_DEPTH; i++) mem[i] = $urandom;
        test_reset();
        test_idle_poll();
        test_single_block();
        test_backpressure();
        test_wrap();
        test_reset_mid_block();
        test_ovf();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ddc_buf_reader.md
# ddc_buf_reader

Local-bus read master on lbs_clk that drains the DDC conversion ring buffer into an AXI-Stream style block interface. It polls the buffer write pointer, computes available samples against its own read pointer, and fetches fixed-length blocks through the same single-cycle-registered read port that serves host reads. It feeds the host-side packetiser downstream.

## Interface
- U_DLY, 1: simulation delay on registered assignments
- BUF_DEPTH, 11520: ring size in words (addresses 0..BUF_DEPTH-1)
- WPTR_ADDR, 11521: local-bus address returning {18'd0, waddr[13:0]}
- BLK_LEN, 256: words per output block
- POLL_GAP, 64: idle cycles between pointer polls when data is insufficient
- rst_n  in  1  reset, asynchronous, active-low
- lbs_clk  in  1  clock; all logic in this domain
- enable  in  1  level; 0 finishes the current block, then holds IDLE
- lbs_addr  out  16  read address to buffer port
- lbs_re  out  1  read strobe, one per issued address
- lbs_rdata  in  32  registered read data; valid 2 edges after address is driven
- m_tvalid  out  1  output word valid
- m_tdata  out  32  sample {I[31:16], Q[15:0]}, passed unmodified
- m_tlast  out  1  high on word BLK_LEN-1 of each block
- m_tready  in  1  downstream accept
- rptr  out  14  current read pointer
- ovf  out  1  sticky reader-lagging flag (see Configuration)

## Operation
- Reset: lbs_addr=0, lbs_re=0, m_tvalid=0, m_tdata=0, m_tlast=0, rptr=0, ovf=0, FSM=IDLE, FIFO empty.
- FSM: IDLE -> POLL when enable=1. POLL: drive lbs_addr=WPTR_ADDR, lbs_re=1 for 1 cycle -> WAITW. WAITW: 2 cycles, capture wptr=lbs_rdata[13:0] -> CALC.
- CALC: avail = (wptr>=rptr) ? wptr-rptr : wptr+BUF_DEPTH-rptr (15-bit arithmetic). avail>=BLK_LEN -> READ, else -> GAP.
- wptr>=BUF_DEPTH is invalid: treated as avail=0 (-> GAP), rptr unchanged.
- GAP: count POLL_GAP cycles -> POLL (or IDLE if enable=0).
- READ: issue addresses rptr, rptr+1, ... one per cycle while (FIFO free slots - in-flight) > 0; rptr wraps BUF_DEPTH-1 -> 0. After BLK_LEN issues -> DRAIN.
- DRAIN: wait until in-flight=0 -> POLL if enable=1 else IDLE.
- Return path: 2-stage valid shift register aligned with lbs_re writes lbs_rdata into an 8-deep FIFO; in-flight counter 0..3.
- Output: FIFO head drives m_tdata/m_tvalid; word popped when m_tvalid&&m_tready. Output word counter 0..BLK_LEN-1 drives m_tlast, wraps after the last word.
- enable deasserting mid-block never truncates a block; data already issued always emerges.

## Timing
- Read latency: address/lbs_re at edge k, data captured at edge k+2.
- Peak throughput 1 word/cycle with m_tready held high; poll overhead 4 cycles/block (POLL, WAITW x2, CALC).
- m_tvalid, once asserted, holds with stable m_tdata/m_tlast until accepted.
- FIFO full with 0 in-flight: issue stalls, no word dropped. FIFO never overflows: issue gated on free-slot accounting.
- Simultaneous FIFO push and pop on a full FIFO: both occur, count unchanged.
- Reset mid-block: all state cleared immediately; next block restarts at rptr=0.

## Configuration
- DDC_RD_OVF_DET_EN defined: in CALC, avail > BUF_DEPTH-BLK_LEN sets ovf (sticky until reset) and resyncs rptr=wptr, then -> GAP; no block read that cycle.
- Undefined: no check; ovf tied 0; large avail read normally.

## Test plan
- Reset, enable=1, wptr=0 -> POLL repeats every POLL_GAP+4 cycles, m_tvalid stays 0.
- wptr=256, m_tready=1 -> addresses 0..255 issued, 256 words out matching buffer contents, m_tlast only on word 255, rptr=256.
- rptr=11392, wptr=128 (wrap) -> avail=256, addresses 11392..11519 then 0..127, one block with correct order.
- m_tready toggling 1/0 every 3 cycles, wptr=512 -> two blocks, no loss/duplication, m_tvalid never drops before accept, FIFO count <=8.
- With DDC_RD_OVF_DET_EN, rptr=0, wptr=11400 -> ovf=1, rptr=11400, no output; without macro -> block read, ovf=0.
- Reset asserted at word 100 of a block -> all outputs to reset values same cycle; after release, wptr=256 yields full block from address 0.
